freq_meas_ctrl: RTL and testbench
=================================

Name: freq_meas_ctrl

Overview:
- Measurement sequencer for the equal-precision frequency counter core.
- Generates the preset gate, waits for the core's update flag, and latches the binary frequency result.
- Converts the result to 8-digit BCD with a multi-cycle shift-add-3 engine and presents it to the 74HC595 display driver.
- Holds the display for a fixed time between measurements.
- Flags a timeout when no input signal is present, and overflow when the result exceeds 8 digits.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- HOLD_MS, 200, display hold time after each result, in ms.
- TIMEOUT_MS, 2000, maximum wait for Update_Flag after the gate falls, in ms.
- RES_W, 32, width of the Freq_Result input.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- run_en  in  1  level; 1 = continuous measurement, 0 = stop after the current cycle.
- gate_sel  in  2  gate length: 00 = 1000 ms, 01 = 100 ms, 10 = 10 ms, 11 = 1000 ms. Sampled on IDLE->GATE.
- Update_Flag  in  1  one-cycle pulse from the core when Freq_Result is valid.
- Freq_Result  in  RES_W  binary frequency in Hz.
- Gate_o  out  1  preset gate to the core.
- disp_data  out  32  8 BCD digits, digit 7 in [31:28].
- disp_valid  out  1  one-cycle pulse when disp_data changes.
- busy  out  1  high in any state except IDLE.
- timeout  out  1  sticky until the next valid result; no-signal indication.
- ovf  out  1  sticky until the next valid result; result above 99_999_999.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Millisecond tick:
  - Free-running prescaler, modulo CLK_FREQ/1000.
  - Tick is one cycle wide.
  - Prescaler is reset on every state entry, so durations are exact to ±0 cycles.
- FSM states: IDLE, GATE, WAIT_UPD, CONV, HOLD.
- IDLE:
  - If run_en = 1, go to GATE next cycle and latch gate_sel.
  - Gate_o rises in the same cycle GATE is entered (registered output).
- GATE:
  - Gate_o = 1 for exactly G × (CLK_FREQ/1000) cycles, where G = 1000, 100 or 10.
  - Then Gate_o = 0 and go to WAIT_UPD.
- WAIT_UPD:
  - On Update_Flag: latch Freq_Result and go to CONV.
  - If TIMEOUT_MS elapses first: disp_data = 0, timeout = 1, ovf = 0, pulse disp_valid, go to HOLD.
  - Update_Flag outside WAIT_UPD is ignored.
- CONV:
  - Result ≥ 100_000_000: ovf = 1, value saturated to 99_999_999 before conversion.
  - Sequential double-dabble on the low 27 bits, one bit per cycle: 27 cycles, plus 1 load and 1 output cycle.
  - Latency from Update_Flag to disp_valid is exactly 29 cycles.
  - At completion: disp_data updates, disp_valid pulses, timeout clears. Go to HOLD.
- HOLD:
  - Wait HOLD_MS.
  - Then go to GATE if run_en = 1, else IDLE.
- run_en falling in GATE, WAIT_UPD or CONV: the current cycle completes normally; the FSM ends in IDLE after HOLD.
- gate_sel change mid-cycle: no effect until the next IDLE->GATE or HOLD->GATE transition (gate_sel is re-sampled there).
- Asynchronous reset mid-operation: immediate return to reset values; Gate_o drops without a glitch.
- disp_data stays stable outside its single update cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits of disp_data are replaced by 4'hF (the driver's blank code).
  - Digit 0 is never blanked; a value of 0 shows a single "0".
  - Blanking is applied in the CONV output cycle, so latency is unchanged.
- Undefined: all 8 digits are output as raw BCD.

Decomposition:
- Package freq_meas_pkg:
  - State enum.
  - Gate length constants GATE_1000MS, GATE_100MS, GATE_10MS (in ms).
  - MAX_DISP = 99_999_999.
  - BLANK_DIGIT = 4'hF.
- Sub-module bcd_seq_conv:
  - Ports: start, bin[26:0], done, bcd[31:0].
  - Implements the 27-bit sequential shift-add-3 engine.
  - FSM instantiates it once.

Test Plan:
- CLK_FREQ = 1000 (tick every cycle), gate_sel = 01, run_en = 1 -> Gate_o high exactly 100 cycles. Update_Flag with Freq_Result = 12_345_678 -> disp_data = 32'h12345678 and disp_valid exactly 29 cycles later; busy stays high.
- Freq_Result = 150_000_000 -> disp_data = 32'h99999999, ovf = 1. Next result 50 -> ovf = 0, disp_data = 32'h00000050.
- No Update_Flag after the gate -> after 2000 ms: timeout = 1, disp_data = 0, one disp_valid pulse. Next valid result clears timeout.
- run_en deasserted mid-GATE -> gate completes, conversion completes, HOLD completes, then IDLE with busy = 0. No further Gate_o.
- Rst_n asserted mid-CONV -> all outputs 0 immediately. After release with run_en = 1, a fresh GATE starts.
- With LEADING_ZERO_BLANK_EN: result 1234 -> disp_data = 32'hFFFF1234; result 0 -> 32'hFFFFFFF0.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-measurement sequencer.
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_WAIT_UPD,
        ST_CONV,
        ST_HOLD
    } state_t;

    localparam logic [15:0] GATE_1000MS = 16'd1000;
    localparam logic [15:0] GATE_100MS  = 16'd100;
    localparam logic [15:0] GATE_10MS   = 16'd10;
    localparam logic [26:0] MAX_DISP    = 27'd99_999_999;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

    function automatic logic [15:0] gate_len_ms(input logic [1:0] sel);
        case (sel)
            2'b01:   return GATE_100MS;
            2'b10:   return GATE_10MS;
            default: return GATE_1000MS;
        endcase
    endfunction

    // Digit 0 is never blanked so a zero reading still shows "0".
    function automatic logic [31:0] blank_lz(input logic [31:0] bcd);
        logic [31:0] r;
        logic        lead;
        r    = bcd;
        lead = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) r[4*i +: 4] = BLANK_DIGIT;
            else                                 lead = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// 27-bit sequential shift-add-3 converter: load on start, one bit per cycle,
// done pulses for one cycle 28 cycles after start with bcd already final.
module bcd_seq_conv (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [26:0] bin,
    output logic        done,
    output logic [31:0] bcd
);
    logic [26:0] r_sh;
    logic [31:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic [31:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 8; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_sh   <= bin;
            r_bcd  <= '0;
            r_cnt  <= 5'd27;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != 5'd0) begin
                {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
                r_cnt         <= r_cnt - 5'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done = r_busy && (r_cnt == 5'd0);
    assign bcd  = r_bcd;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gate / wait / convert / hold sequencer for the frequency counter; 29-cycle Update_Flag->disp_valid.
// LEADING_ZERO_BLANK_EN: blank leading zero digits with 4'hF in the conversion output cycle.
module freq_meas_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int HOLD_MS    = 200,
    parameter int TIMEOUT_MS = 2000,
    parameter int RES_W      = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             run_en,
    input  logic [1:0]       gate_sel,
    input  logic             Update_Flag,
    input  logic [RES_W-1:0] Freq_Result,
    output logic             Gate_o,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic             busy,
    output logic             timeout,
    output logic             ovf
);
    import freq_meas_pkg::*;

    localparam int CYC_PER_MS = CLK_FREQ / 1000;
    localparam int PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;

    state_t            r_state, w_nxt;
    logic [PRE_W-1:0]  r_pre;
    logic [15:0]       r_ms;
    logic [15:0]       r_gate_ms;
    logic              r_gate, r_dvld, r_tmo, r_ovf, r_ovf_pend;
    logic [31:0]       r_disp;
    logic              w_tick, w_gate_end, w_upd, w_tmo, w_conv_done, w_hold_end, w_start_gate;
    logic [26:0]       w_sat;
    logic              w_done;
    logic [31:0]       w_bcd, w_disp_out;

    assign w_tick       = (r_pre == PRE_W'(CYC_PER_MS - 1));
    assign w_gate_end   = (r_state == ST_GATE) && w_tick && (r_ms == r_gate_ms - 16'd1);
    assign w_upd        = (r_state == ST_WAIT_UPD) && Update_Flag;
    assign w_tmo        = (r_state == ST_WAIT_UPD) && !Update_Flag && w_tick
                          && (r_ms == 16'(TIMEOUT_MS - 1));
    assign w_conv_done  = (r_state == ST_CONV) && w_done;
    assign w_hold_end   = (r_state == ST_HOLD) && w_tick && (r_ms == 16'(HOLD_MS - 1));
    assign w_start_gate = run_en && ((r_state == ST_IDLE) || w_hold_end);
    assign w_sat        = (Freq_Result > RES_W'(MAX_DISP)) ? MAX_DISP : Freq_Result[26:0];

`ifdef LEADING_ZERO_BLANK_EN
    assign w_disp_out = blank_lz(w_bcd);
`else
    assign w_disp_out = w_bcd;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (run_en) w_nxt = ST_GATE;
            ST_GATE:     if (w_gate_end) w_nxt = ST_WAIT_UPD;
            ST_WAIT_UPD: if (w_upd) w_nxt = ST_CONV;
                         else if (w_tmo) w_nxt = ST_HOLD;
            ST_CONV:     if (w_conv_done) w_nxt = ST_HOLD;
            ST_HOLD:     if (w_hold_end) w_nxt = run_en ? ST_GATE : ST_IDLE;
            default:     w_nxt = ST_IDLE;
        endcase
    end

    bcd_seq_conv u_conv (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (w_upd),
        .bin   (w_sat),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_IDLE;
            r_pre      <= '0;
            r_ms       <= '0;
            r_gate_ms  <= '0;
            r_gate     <= 1'b0;
            r_dvld     <= 1'b0;
            r_tmo      <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_state <= w_nxt;
            // Restarting the ms prescaler on every state entry keeps durations cycle-exact.
            if (w_nxt != r_state) begin
                r_pre <= '0;
                r_ms  <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_ms  <= r_ms + 16'd1;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end

            if (w_start_gate) begin
                r_gate    <= 1'b1;
                r_gate_ms <= gate_len_ms(gate_sel);
            end else if (w_gate_end) begin
                r_gate <= 1'b0;
            end

            if (w_upd) r_ovf_pend <= (Freq_Result > RES_W'(MAX_DISP));

            r_dvld <= 1'b0;
            if (w_tmo) begin
                r_disp <= '0;
                r_dvld <= 1'b1;
                r_tmo  <= 1'b1;
                r_ovf  <= 1'b0;
            end else if (w_conv_done) begin
                r_disp <= w_disp_out;
                r_dvld <= 1'b1;
                r_tmo  <= 1'b0;
                r_ovf  <= r_ovf_pend;
            end
        end
    end

    assign Gate_o     = r_gate;
    assign disp_data  = r_disp;
    assign disp_valid = r_dvld;
    assign busy       = (r_state != ST_IDLE);
    assign timeout    = r_tmo;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with CLK_FREQ=1000 so one ms tick is one clock.
module tb_freq_meas_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] E50   = 32'hFFFFFF50;
    localparam logic [31:0] E7    = 32'hFFFFFFF7;
    localparam logic [31:0] E1234 = 32'hFFFF1234;
    localparam logic [31:0] E0    = 32'hFFFFFFF0;
`else
    localparam logic [31:0] E50   = 32'h00000050;
    localparam logic [31:0] E7    = 32'h00000007;
    localparam logic [31:0] E1234 = 32'h00001234;
    localparam logic [31:0] E0    = 32'h00000000;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic [1:0]  gate_sel = 2'b01;
    logic        Update_Flag = 1'b0;
    logic [31:0] Freq_Result = '0;
    logic        Gate_o, disp_valid, busy, timeout, ovf;
    logic [31:0] disp_data;

    int n_vec = 0;
    int n_miscmp = 0;
    int glen, lat, n, seen;

    freq_meas_ctrl #(
        .CLK_FREQ   (1000),
        .HOLD_MS    (200),
        .TIMEOUT_MS (2000),
        .RES_W      (32)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .run_en      (run_en),
        .gate_sel    (gate_sel),
        .Update_Flag (Update_Flag),
        .Freq_Result (Freq_Result),
        .Gate_o      (Gate_o),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .busy        (busy),
        .timeout     (timeout),
        .ovf         (ovf)
    );

    always #5 Clk = ~Clk;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Waits for a gate, counts its length, optionally sends a result and measures latency.
    task automatic measure(input logic [31:0] res, input logic [1:0] sel_after, input bit drop_run,
                           input bit send_upd, output int gl, output int lt);
        int k;
        gl = 0;
        lt = 0;
        k  = 0;
        while (!Gate_o && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        if (!Gate_o) begin
            check_vec("gate_rise_tmo", 32'd0, 32'd1);
            return;
        end
        check_vec("busy_in_gate", {31'd0, busy}, 32'd1);
        gate_sel = sel_after;
        while (Gate_o && gl < 3000) begin
            gl++;
            if (drop_run && gl == 5) run_en = 1'b0;
            @(negedge Clk);
        end
        if (!send_upd) return;
        repeat (2) @(negedge Clk);
        Update_Flag = 1'b1;
        Freq_Result = res;
        @(negedge Clk);
        Update_Flag = 1'b0;
        lt = 1;
        while (!disp_valid && lt < 60) begin
            @(negedge Clk);
            lt++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_data,
                                input logic exp_ovf, input logic exp_tmo);
        check_vec({tag, "_data"}, disp_data, exp_data);
        check_vec({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check_vec({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_tmo});
        @(negedge Clk);
        check_vec({tag, "_valid_pulse"}, {31'd0, disp_valid}, 32'd0);
        check_vec({tag, "_data_hold"}, disp_data, exp_data);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_vec("rst_gate", {31'd0, Gate_o}, 32'd0);
        check_vec("rst_busy", {31'd0, busy}, 32'd0);
        check_vec("rst_valid", {31'd0, disp_valid}, 32'd0);
        check_vec("rst_timeout", {31'd0, timeout}, 32'd0);
        check_vec("rst_ovf", {31'd0, ovf}, 32'd0);
        check_vec("rst_data", disp_data, 32'd0);

        Rst_n  = 1'b1;
        run_en = 1'b1;

        // gate_sel changed mid-gate must not shorten this gate.
        measure(32'd12_345_678, 2'b10, 1'b0, 1'b1, glen, lat);
        check_vec("m1_gate_len", 32'(glen), 32'd100);
        check_vec("m1_latency", 32'(lat), 32'd29);
        check_vec("m1_busy", {31'd0, busy}, 32'd1);
        check_result("m1", 32'h12345678, 1'b0, 1'b0);

        measure(32'd150_000_000, 2'b10, 1'b0, 1'b1, glen, lat);
        check_vec("m2_gate_len", 32'(glen), 32'd10);
        check_vec("m2_latency", 32'(lat), 32'd29);
        check_result("m2", 32'h99999999, 1'b1, 1'b0);

        measure(32'd0, 2'b01, 1'b0, 1'b0, glen, lat);
        check_vec("to_gate_len", 32'(glen), 32'd10);
        n = 0;
        while (!disp_valid && n < 2200) begin
            @(negedge Clk);
            n++;
        end
        check_vec("to_wait_cycles", 32'(n), 32'd2000);
        check_result("to", 32'd0, 1'b0, 1'b1);

        measure(32'd50, 2'b01, 1'b0, 1'b1, glen, lat);
        check_vec("m3_gate_len", 32'(glen), 32'd100);
        check_vec("m3_latency", 32'(lat), 32'd29);
        check_result("m3", E50, 1'b0, 1'b0);

        // run_en dropped mid-gate: cycle completes, then the FSM parks in IDLE.
        measure(32'd7, 2'b01, 1'b1, 1'b1, glen, lat);
        check_vec("stop_gate_len", 32'(glen), 32'd100);
        check_vec("stop_latency", 32'(lat), 32'd29);
        check_result("stop", E7, 1'b0, 1'b0);
        n = 1;
        while (busy && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check_vec("stop_hold_cycles", 32'(n), 32'd200);
        seen = 0;
        repeat (300) begin
            @(negedge Clk);
            if (Gate_o || busy) seen++;
        end
        check_vec("stop_idle", 32'(seen), 32'd0);

        run_en = 1'b1;
        measure(32'd0, 2'b01, 1'b0, 1'b0, glen, lat);
        check_vec("rst_cyc_gate_len", 32'(glen), 32'd100);
        @(negedge Clk);
        Update_Flag = 1'b1;
        Freq_Result = 32'd1234;
        @(negedge Clk);
        Update_Flag = 1'b0;
        repeat (10) @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check_vec("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_vec("mid_rst_data", disp_data, 32'd0);
        check_vec("mid_rst_flags", {29'd0, Gate_o, disp_valid, timeout}, 32'd0);
        check_vec("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_vec("regate_after_rst", {31'd0, Gate_o}, 32'd1);

        measure(32'd1234, 2'b01, 1'b0, 1'b1, glen, lat);
        check_vec("m4_gate_len", 32'(glen), 32'd100);
        check_vec("m4_latency", 32'(lat), 32'd29);
        check_result("m4", E1234, 1'b0, 1'b0);

        measure(32'd0, 2'b01, 1'b0, 1'b1, glen, lat);
        check_vec("m5_latency", 32'(lat), 32'd29);
        check_result("m5", E0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
